// File: rtl/add_approx_pipe.sv
// Elastic pipelined adder with an OR-based approximate low part, per-transaction
// exact override, and running error statistics on delivered results.
module add_approx_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4,
  parameter int LATENCY     = 2,
  parameter int CNT_W       = 16,
  parameter int ERR_W       = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_exact,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic [WIDTH:0]     out_err,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   op_count,
  output logic [ERR_W-1:0]   err_sum,
  output logic [WIDTH:0]     err_max
);

  localparam int SW = WIDTH + 1;
  localparam int KI = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;

  function automatic logic [SW-1:0] approx_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [SW-1:0] lo;
    logic [SW-1:0] hi;
    logic          c;
    lo = '0;
    for (int i = 0; i < APPROX_BITS; i++) lo[i] = a[i] | b[i];
    c  = (APPROX_BITS > 0) ? (a[KI] & b[KI]) : 1'b0;
    hi = ({1'b0, a} >> APPROX_BITS) + ({1'b0, b} >> APPROX_BITS) + SW'(c);
    return lo | (hi << APPROX_BITS);
  endfunction

  function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] x, input logic [SW-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Accumulator is assumed at least as wide as the error value.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc, input logic [SW-1:0] e);
    logic [ERR_W:0] t;
    t = {1'b0, acc} + (ERR_W+1)'(e);
    return t[ERR_W] ? '1 : t[ERR_W-1:0];
  endfunction

  logic [SW-1:0]      exact_c;
  logic [SW-1:0]      sum_c;
  logic [SW-1:0]      err_c;
  logic [LATENCY-1:0] vld_p;
  logic [SW-1:0]      sum_p [LATENCY];
  logic [SW-1:0]      err_p [LATENCY];
  logic [LATENCY-1:0] rdy;
  logic               out_hs;

  always_comb begin
    exact_c = {1'b0, in_a} + {1'b0, in_b};
    sum_c   = (in_exact || APPROX_BITS == 0) ? exact_c : approx_sum(in_a, in_b);
    err_c   = abs_diff(exact_c, sum_c);
  end

  // A stage may load when the output drains or any bubble sits at or after it.
  always_comb begin
    logic bub;
    bub = 1'b0;
    rdy = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      bub    = bub | ~vld_p[i];
      rdy[i] = out_ready | bub;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[LATENCY-1];
  assign out_sum   = sum_p[LATENCY-1];
  assign out_err   = err_p[LATENCY-1];
  assign out_hs    = out_valid & out_ready;

  // stage p0 captures the computed result; later stages shift forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        sum_p[i] <= '0;
        err_p[i] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        vld_p[0] <= in_valid;
        if (in_valid) begin
          sum_p[0] <= sum_c;
          err_p[0] <= err_c;
        end
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (rdy[i]) begin
          vld_p[i] <= vld_p[i-1];
          sum_p[i] <= sum_p[i-1];
          err_p[i] <= err_p[i-1];
        end
      end
    end
  end

  // statistics follow delivered results only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
      err_sum  <= '0;
      err_max  <= '0;
    end else if (clr_stats) begin
      if (out_hs) begin
        op_count <= CNT_W'(1);
        err_sum  <= ERR_W'(out_err);
        err_max  <= out_err;
      end else begin
        op_count <= '0;
        err_sum  <= '0;
        err_max  <= '0;
      end
    end else if (out_hs) begin
      op_count <= sat_inc(op_count);
      err_sum  <= sat_add(err_sum, out_err);
      err_max  <= (out_err > err_max) ? out_err : err_max;
    end
  end

endmodule

// File: tb/tb_add_approx_pipe.sv
// Directed bench for add_approx_pipe: default instance plus a 2-bit counter
// instance and an exact-only instance, all fed from the same stimulus.
module tb_add_approx_pipe;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_exact, out_ready, clr_stats;
  logic [7:0] in_a, in_b;

  logic in_ready, out_valid;
  logic [8:0] out_sum, out_err, err_max;
  logic [15:0] op_count;
  logic [19:0] err_sum;

  logic s_in_ready, s_out_valid;
  logic [8:0] s_out_sum, s_out_err, s_err_max;
  logic [1:0] s_op_count;
  logic [19:0] s_err_sum;

  logic e_in_ready, e_out_valid;
  logic [8:0] e_out_sum, e_out_err, e_err_max;
  logic [15:0] e_op_count;
  logic [19:0] e_err_sum;

  int checks = 0;
  int errors = 0;

  logic [7:0] va [8];
  logic [7:0] vb [8];
  logic       vx [8];
  logic [8:0] xs [8];
  logic [8:0] xe [8];
  logic [8:0] xx [8];

  always #5 clk = ~clk;

  add_approx_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .clr_stats(clr_stats), .op_count(op_count), .err_sum(err_sum), .err_max(err_max)
  );

  add_approx_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_sum(s_out_sum), .out_err(s_out_err),
    .clr_stats(clr_stats), .op_count(s_op_count), .err_sum(s_err_sum), .err_max(s_err_max)
  );

  add_approx_pipe #(.APPROX_BITS(0)) u_ex0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(e_out_valid),
    .out_ready(out_ready), .out_sum(e_out_sum), .out_err(e_out_err),
    .clr_stats(clr_stats), .op_count(e_op_count), .err_sum(e_err_sum), .err_max(e_err_max)
  );

  // Accept one operand pair and stop at the negedge where its result is on the output.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic ex);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_exact = ex;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0;
    out_ready = 1'b1; clr_stats = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== 9'h000 || out_err !== 9'h000) begin errors++; $display("FAIL reset_data: got sum %h err %h want 0 0", out_sum, out_err); end
    checks++; if (op_count !== 16'd0 || err_sum !== 20'd0 || err_max !== 9'd0) begin errors++; $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", op_count, err_sum, err_max); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    run_one(8'h0F, 8'h01, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== 9'h00F || out_err !== 9'd1) begin errors++; $display("FAIL approx_0f_01: got %h/%0d want 00f/1", out_sum, out_err); end
    checks++; if (e_out_sum !== 9'h010 || e_out_err !== 9'd0) begin errors++; $display("FAIL k0_0f_01: got %h/%0d want 010/0", e_out_sum, e_out_err); end
    run_one(8'h08, 8'h08, 1'b0);
    checks++; if (out_sum !== 9'h018 || out_err !== 9'd8) begin errors++; $display("FAIL approx_08_08: got %h/%0d want 018/8", out_sum, out_err); end
    run_one(8'h08, 8'h08, 1'b1);
    checks++; if (out_sum !== 9'h010 || out_err !== 9'd0) begin errors++; $display("FAIL exact_08_08: got %h/%0d want 010/0", out_sum, out_err); end
  endtask

  task automatic test_stats();
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checks++; if (op_count !== 16'd0 || err_sum !== 20'd0 || err_max !== 9'd0) begin errors++; $display("FAIL clr_idle: got %0d %0d %0d want 0 0 0", op_count, err_sum, err_max); end
    run_one(8'hFF, 8'hFF, 1'b0);
    checks++; if (out_sum !== 9'h1FF || out_err !== 9'd1) begin errors++; $display("FAIL approx_ff_ff: got %h/%0d want 1ff/1", out_sum, out_err); end
    run_one(8'hFF, 8'hFF, 1'b1);
    checks++; if (out_sum !== 9'h1FE || out_err !== 9'd0) begin errors++; $display("FAIL exact_ff_ff: got %h/%0d want 1fe/0", out_sum, out_err); end
    @(negedge clk);
    checks++; if (op_count !== 16'd2 || err_sum !== 20'd1 || err_max !== 9'd1) begin errors++; $display("FAIL stats_ff: got %0d %0d %0d want 2 1 1", op_count, err_sum, err_max); end
  endtask

  task automatic test_clr_handshake();
    run_one(8'h08, 8'h08, 1'b0);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checks++; if (op_count !== 16'd1 || err_sum !== 20'd8 || err_max !== 9'd8) begin errors++; $display("FAIL clr_with_hs: got %0d %0d %0d want 1 8 8", op_count, err_sum, err_max); end
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checks++; if (op_count !== 16'd0 || err_sum !== 20'd0 || err_max !== 9'd0) begin errors++; $display("FAIL clr_zero: got %0d %0d %0d want 0 0 0", op_count, err_sum, err_max); end
  endtask

  task automatic test_back_to_back();
    int tx, rx;
    bit saw_block, held;
    logic [8:0] hs, he;
    va = '{8'h0F, 8'h08, 8'hFF, 8'h12, 8'h80, 8'h3C, 8'hFF, 8'h55};
    vb = '{8'h01, 8'h08, 8'hFF, 8'h34, 8'h80, 8'h0C, 8'h01, 8'hAA};
    vx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    xs = '{9'h00F, 9'h018, 9'h1FF, 9'h046, 9'h100, 9'h04C, 9'h100, 9'h0FF};
    xe = '{9'd1, 9'd8, 9'd1, 9'd0, 9'd0, 9'd4, 9'd0, 9'd0};
    xx = '{9'h010, 9'h010, 9'h1FE, 9'h046, 9'h100, 9'h048, 9'h100, 9'h0FF};
    tx = 0; rx = 0; saw_block = 1'b0; held = 1'b0; hs = '0; he = '0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 6);
      if (tx < 8) begin
        in_valid = 1'b1; in_a = va[tx]; in_b = vb[tx]; in_exact = vx[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== hs || out_err !== he) begin errors++; $display("FAIL stall_hold: got v%b %h/%0d want v1 %h/%0d", out_valid, out_sum, out_err, hs, he); end
      end
      held = out_valid && !out_ready;
      hs = out_sum; he = out_err;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        checks++; if (out_sum !== xs[rx] || out_err !== xe[rx]) begin errors++; $display("FAIL b2b_%0d: got %h/%0d want %h/%0d", rx, out_sum, out_err, xs[rx], xe[rx]); end
        checks++; if (e_out_sum !== xx[rx] || e_out_err !== 9'd0) begin errors++; $display("FAIL b2b_k0_%0d: got %h/%0d want %h/0", rx, e_out_sum, e_out_err, xx[rx]); end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (rx != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", rx); end
    checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_backpressure: got %b want 1", saw_block); end
    @(negedge clk);
    checks++; if (op_count !== 16'd8 || err_sum !== 20'd14 || err_max !== 9'd8) begin errors++; $display("FAIL b2b_stats: got %0d %0d %0d want 8 14 8", op_count, err_sum, err_max); end
    checks++; if (s_op_count !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d want 3", s_op_count); end
  endtask

  task automatic test_reset_flight();
    bit seen;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_exact = 1'b0;
    @(negedge clk);
    in_a = 8'h55; in_b = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL flight_full: got v%b r%b want v1 r0", out_valid, in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sum !== 9'h000) begin errors++; $display("FAIL flight_reset: got v%b %h want v0 000", out_valid, out_sum); end
    checks++; if (op_count !== 16'd0 || err_sum !== 20'd0 || err_max !== 9'd0) begin errors++; $display("FAIL flight_stats: got %0d %0d %0d want 0 0 0", op_count, err_sum, err_max); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL flight_discard: got seen %b count %0d want 0 0", seen, op_count); end
  endtask

  task automatic test_exact_sweep();
    logic [7:0] a, b;
    logic [8:0] want;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      want = {1'b0, a} + {1'b0, b};
      run_one(a, b, 1'b0);
      checks++; if (e_out_valid !== 1'b1 || e_out_sum !== want || e_out_err !== 9'd0) begin errors++; $display("FAIL k0_sweep %h+%h: got v%b %h/%0d want v1 %h/0", a, b, e_out_valid, e_out_sum, e_out_err, want); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stats();
    test_clr_handshake();
    test_back_to_back();
    test_reset_flight();
    test_exact_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_approx_pipe.md
ADD_APPROX_PIPE -- requirements
Module: add_approx_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (2..32).
REQ-002 The block SHALL have parameter APPROX_BITS, default 4, meaning the number of LSBs computed by the approximate lower part (0..WIDTH; 0 = exact adder).
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning the number of register stages from input handshake to output (1..4).
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of the operation counter.
REQ-005 The block SHALL have parameter ERR_W, default 20, meaning the width of the error accumulator.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a and in_b (input, WIDTH), in_exact (input, 1), meaning the operand handshake and a per-transaction exact-mode request.
REQ-009 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sum (output, WIDTH+1), out_err (output, WIDTH+1), meaning the result handshake, the sum, and |exact - out_sum| for that transaction.
REQ-010 The block SHALL have ports clr_stats (input, 1), op_count (output, CNT_W), err_sum (output, ERR_W), err_max (output, WIDTH+1), meaning the statistics clear and the running error statistics.

Function
REQ-011 A transaction SHALL be accepted on a rising edge where in_valid and in_ready are both 1, and delivered on an edge where out_valid and out_ready are both 1.
REQ-012 Approximate sum, K = APPROX_BITS: bit i < K = in_a[i] OR in_b[i]; carry into bit K = in_a[K-1] AND in_b[K-1] (0 when K = 0); bits K..WIDTH = exact sum of upper operand bits plus that carry.
REQ-013 When in_exact = 1 or K = 0, out_sum SHALL be the exact in_a + in_b and out_err SHALL be 0.
REQ-014 out_err SHALL be the unsigned magnitude of (exact sum - out_sum), computed on the full WIDTH+1 values.
REQ-015 The datapath SHALL be an elastic LATENCY-stage pipeline; each stage holds a valid bit and advances when the next stage is empty or draining that cycle.
REQ-016 With out_ready held 1, a transaction accepted at edge n SHALL appear with out_valid = 1 after edge n+LATENCY-1, and throughput SHALL be one transaction per cycle.
REQ-017 in_ready SHALL be 1 whenever stage 0 is empty or stage 0 advances in the same cycle; it may combinationally depend on out_ready.
REQ-018 While out_valid = 1 and out_ready = 0, out_sum and out_err SHALL hold stable and no transaction SHALL be lost, duplicated or reordered.
REQ-019 On each output handshake, op_count SHALL increment by 1, err_sum SHALL add out_err, err_max SHALL take max(err_max, out_err).
REQ-020 op_count and err_sum SHALL saturate at all-ones and never wrap.
REQ-021 clr_stats = 1 SHALL zero all three statistics at the next edge; if an output handshake occurs in the same cycle, the statistics SHALL instead load that transaction alone (op_count = 1, err_sum = err_max = out_err).
REQ-022 Statistics SHALL be updated only on output handshakes, never on acceptance.

Reset
REQ-023 While rst_n = 0 all stage valids, out_valid, op_count, err_sum and err_max SHALL be 0 immediately (asynchronously); out_sum and out_err SHALL be 0.
REQ-024 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight transactions; none SHALL be delivered after reset release.

Verification (WIDTH=8, APPROX_BITS=4, LATENCY=2 unless stated)
REQ-026 in_a=0x0F, in_b=0x01, in_exact=0 -> out_sum=0x00F, out_err=1 two edges after acceptance.
REQ-027 in_a=0x08, in_b=0x08, in_exact=0 -> out_sum=0x018, out_err=8; same operands with in_exact=1 -> out_sum=0x010, out_err=0.
REQ-028 in_a=0xFF, in_b=0xFF approx, then exact -> out_sum 0x1FF/err 1, then 0x1FE/err 0; op_count=2, err_sum=1, err_max=1.
REQ-029 Back-to-back stream of 8 transactions with out_ready low for 3 cycles mid-stream -> in_ready drops once the pipe is full, all 8 results delivered in order, values stable while stalled.
REQ-030 clr_stats asserted on a cycle with an output handshake of err 8 -> op_count=1, err_sum=8, err_max=8; with CNT_W=2, 5 handshakes -> op_count=3 (saturated).
REQ-031 rst_n pulsed low with 2 transactions in flight -> out_valid=0 at once, statistics 0, no result delivered after release; APPROX_BITS=0 random sweep -> out_err always 0.
